// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, fetch FSM encodings,
// instruction field positions and the default reset vector.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 16;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [31:0]        pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction word and its address,
// used when memory returns data while decode is stalled.
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  fetch_word_t word_i,
    output logic        full_o,
    output fetch_word_t word_o
);

    logic        full_q, full_d;
    fetch_word_t word_q, word_d;

    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (clear_i || drain_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            word_d = word_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign full_o = full_q;
    assign word_o = word_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC, imem req/ack, redirect and skid.
// Define FETCH_COUNT_EN to add the fetch_count consumption counter.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        pc_plus4,
`ifdef FETCH_COUNT_EN
    output logic [31:0]        fetch_count,
`endif
    output logic [IMM_W-1:0]   imm
);

    logic [1:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        ipc_q, ipc_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        tgt_q, tgt_d;

    logic        consume;
    logic [31:0] rpc;
    logic [31:0] next_addr;
    logic        skid_load, skid_drain, skid_clear, skid_full;
    fetch_word_t skid_in, skid_out;

    assign consume   = valid_q & ~stall;
    assign rpc       = word_align(redirect_pc);
    assign next_addr = addr_q + 32'd4;
    assign skid_in   = '{data: imem_data, pc: addr_q};

    fetch_skid u_skid (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .word_i  (skid_in),
        .full_o  (skid_full),
        .word_o  (skid_out)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        addr_d     = addr_q;
        tgt_d      = tgt_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        unique case (state_q)
            ST_START: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (imem_ack) begin
                        addr_d = rpc;
                    end else begin
                        tgt_d   = rpc;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    addr_d = next_addr;
                    if (valid_q && stall) begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        instr_d = imem_data;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    skid_clear = 1'b1;
                    addr_d     = rpc;
                    state_d    = ST_REQ;
                end else if (consume && skid_full) begin
                    instr_d    = skid_out.data;
                    ipc_d      = skid_out.pc;
                    skid_drain = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Outstanding word belongs to the abandoned path.
                if (redirect) begin
                    tgt_d = rpc;
                end else if (imem_ack) begin
                    addr_d  = tgt_q;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_START;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            addr_q  <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (consume) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign fetch_count = cnt_q;
`endif

    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr = addr_q;
    assign valid     = valid_q;
    assign instr     = instr_q;
    assign instr_pc  = ipc_q;
    assign pc_plus4  = ipc_q + 32'd4;
    assign imm       = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic,
// checked against a queue-based model of presented/buffered words.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [15:0] imm;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .valid       (valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
`ifdef FETCH_COUNT_EN
        .fetch_count (fetch_count),
`endif
        .imm         (imm)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    // Model: words owned by the stage (front is presented, second is the
    // buffered one), the fetch address, and whether a dead request is open.
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_first;
    bit          m_drain;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pc    = 32'h0000_0000;
        m_tgt   = '0;
        m_first = 1'b1;
        m_drain = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_edge(input bit s, input bit r,
                                       input logic [31:0] rp, input bit a,
                                       input logic [31:0] d);
        bit          cons;
        logic [31:0] t;
        cons = (mq.size() > 0) && !s;
        t    = rp & 32'hFFFF_FFFC;
        if (cons) m_cnt++;
        if (m_first) begin
            m_first = 1'b0;
        end else if (r) begin
            if (mq.size() == 2) begin
                mq.delete();
                m_pc = t;
            end else if (m_drain) begin
                m_tgt = t;
            end else begin
                mq.delete();
                if (a) m_pc = t;
                else begin
                    m_drain = 1'b1;
                    m_tgt   = t;
                end
            end
        end else if (m_drain) begin
            if (a) begin
                m_drain = 1'b0;
                m_pc    = m_tgt;
            end
        end else if (mq.size() == 2) begin
            if (cons) void'(mq.pop_front());
        end else begin
            if (cons) void'(mq.pop_front());
            if (a) begin
                mq.push_back('{d: d, p: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic compare();
        bit ev;
        ev = mq.size() > 0;
        chk("valid", {31'd0, valid}, {31'd0, ev});
        chk("imem_req", {31'd0, imem_req},
            {31'd0, !m_first && mq.size() != 2});
        chk("imem_addr", imem_addr, m_pc);
        if (ev) begin
            chk("instr", instr, mq[0].d);
            chk("instr_pc", instr_pc, mq[0].p);
            chk("pc_plus4", pc_plus4, mq[0].p + 32'd4);
            chk("imm", {16'd0, imm}, {16'd0, mq[0].d[15:0]});
        end
`ifdef FETCH_COUNT_EN
        chk("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] rp,
                        input bit a, input logic [31:0] d);
        bit a_used;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        a_used      = a && imem_req;
        imem_ack    = a_used;
        imem_data   = d;
        @(posedge clock);
        model_edge(s, r, rp, a_used, d);
        #1 imem_ack = 1'b0;
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        compare();
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        compare();
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h2008_0005);
        chk("first_pc", instr_pc, 32'h0);
        chk("first_imm", {16'd0, imm}, 32'h0005);
        step(0, 0, 0, 1, 32'h2009_0007);
        chk("second_imm", {16'd0, imm}, 32'h0007);
        chk("second_addr", imem_addr, 32'h8);

        step(1, 0, 0, 1, 32'h1234_ABCD);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_instr", instr, 32'h2009_0007);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("skid_instr", instr, 32'h1234_ABCD);
        chk("skid_pc", instr_pc, 32'h8);
        chk("skid_addr", imem_addr, 32'hC);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hAAAA_0001);
        step(0, 1, 32'h0040_0013, 0, 0);
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hDEAD_0000);
        chk("drain_target", imem_addr, 32'h0040_0010);
        chk("drain_valid", {31'd0, valid}, 32'd0);

        step(0, 1, 32'h0000_0100, 1, 32'hBEEF_0000);
        chk("redir_ack_addr", imem_addr, 32'h100);
        chk("redir_ack_valid", {31'd0, valid}, 32'd0);

        step(0, 1, 32'hFFFF_FFFE, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 32'h1111_2222);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        step(0, 1, 32'h0000_0040, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, $urandom);
`ifdef FETCH_COUNT_EN
        chk("count5", fetch_count, 32'd5);
`endif

        for (int i = 0; i < 2000; i++) begin
            bit          s, r, a;
            logic [31:0] t;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                step(0, 0, 0, 0, 0);
            end else begin
                s = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 11) == 0);
                a = ($urandom_range(0, 1) == 0);
                t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
                step(s, r, t, a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the MIPS datapath; sits directly upstream of the immediate extender.
- Keeps the PC and runs a req/ack transaction with instruction memory.
- Presents one fetched instruction at a time to decode, holding it while decode stalls; drives the 16-bit immediate field to the extender.
- Handles branch/jump redirects, with a 1-entry skid buffer for data returned while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; instruction outputs must hold.
- redirect  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target address; bits [1:0] ignored and forced to 0.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address; stable from req assertion through the ack cycle.
- imem_ack  in  1  single-cycle pulse; imem_data valid in the same cycle.
- imem_data  in  32  instruction word.
- valid  out  1  instr holds an unconsumed instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- pc_plus4  out  32  instr_pc + 4, modulo 2^32.
- imm  out  16  instr[15:0], feeds the extender.

Behaviour:
- Reset (async, active-high): state START; valid=0; instr=0; instr_pc=0; imem_req=0; imem_addr=RESET_PC; skid empty.
- Consumption: occurs at a clock edge where valid=1 and stall=0.
- Memory protocol: imem_req is high only in REQ and DRAIN. A new transaction starts the cycle after an ack if imem_req is still high.
- START: always goes to REQ on the next cycle.
- REQ (imem_req=1), ack arrives, no redirect:
  - If valid=1 and stall=1: load skid with data and addr; imem_addr += 4; go to HOLD.
  - Otherwise: instr<=data; instr_pc<=imem_addr; valid<=1; imem_addr += 4; stay in REQ.
  - Fetch latency is ack cycle + 1 edge. Back-to-back acks give one instruction per cycle.
- REQ, no ack: on consumption, valid<=0.
- HOLD (imem_req=0): on consumption, instr/instr_pc<=skid contents; valid stays 1; skid cleared; go to REQ.
- Redirect has priority over stall and ack, and always clears valid:
  - REQ with ack in the same cycle: data discarded; imem_addr<=redirect_pc; stay in REQ.
  - REQ without ack: target saved; go to DRAIN.
  - HOLD: skid discarded; imem_addr<=redirect_pc; go to REQ.
  - DRAIN: saved target overwritten; stay in DRAIN.
- DRAIN (imem_req=1, old address held): on ack, data discarded; imem_addr<=saved target; go to REQ.
- Wrap-around: address increment is modulo 2^32, so 0xFFFF_FFFC -> 0x0000_0000.
- Reset mid-transaction: immediate return to reset values; any ack arriving while reset is asserted is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: adds output fetch_count, 32 bits. Reset to 0; +1 on every consumption; wraps at 2^32; unaffected by redirect.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_W=32, IMM_W=16.
  - State encodings START/REQ/HOLD/DRAIN.
  - Instruction field positions (opcode [31:26], imm [15:0]).
  - Default reset vector.
- One natural sub-module: fetch_skid, a 1-entry data+pc holding register with full flag, load, drain and clear.

Test Plan:
- Reset release, memory acks every cycle with data 0x2008_0005, 0x2009_0007 -> imem_addr 0x0, 0x4, 0x8; valid rises one edge after the first ack; instr_pc 0x0 then 0x4; imm 0x0005 then 0x0007.
- Stall held 3 cycles while ack returns 0x1234_ABCD at 0x8 -> instr unchanged; skid holds 0x1234_ABCD; imem_req=0; after stall drops, instr=0x1234_ABCD, instr_pc=0x8, imem_addr=0xC.
- Redirect to 0x0040_0013 while a request to 0x10 is outstanding (ack 2 cycles later) -> valid=0 immediately; ack for 0x10 discarded; next imem_addr=0x0040_0010.
- Redirect and ack in the same cycle -> data dropped; next imem_addr equals target; no valid pulse for the dropped word.
- RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000; pc_plus4 of the first instruction = 0x0.
- Reset asserted mid-DRAIN -> imem_req=0 asynchronously, valid=0; with FETCH_COUNT_EN, fetch_count=0 and counts 5 after 5 consumptions.
